// File: rtl/alu_sched_if.sv
// Requester-side channel of alu_sched: one request/response handshake pair per requester.
// The scheduler uses the slave view; a requester (or bench) uses the master view.
interface alu_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_r;
    logic        resp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_r, resp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_r, resp_zero
    );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler for one shared combinational ALU, one operation in flight.
// Define ALU_SCHED_MULTISHIFT_EN to run shifts (0101/0110) as b[5:0] repeated shift-by-1 steps.
module alu_sched #(
    parameter int PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              rst,
    alu_sched_if.slave        port0,
    alu_sched_if.slave        port1,
    output logic [63:0]       alu_a,
    output logic [63:0]       alu_b,
    output logic [3:0]        alu_op,
    input  logic [63:0]       alu_r,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic        grant_id;
    logic        last_grant;
    logic        pick;
    logic        accept;
    logic        exec_done;
    logic        resp_ready_sel;
    logic        in_resp;
    logic [63:0] lat_a;
    logic [63:0] lat_b;
    logic [3:0]  lat_op;
    logic [63:0] res_r;
    logic        res_zero;
    logic [63:0] cap_r;
    logic        cap_zero;
    logic        v0;
    logic        v1;
    logic [63:0] sel_a;
    logic [63:0] sel_b;
    logic [3:0]  sel_op;
`ifdef ALU_SCHED_MULTISHIFT_EN
    logic [5:0]  shift_cnt;
    logic        shift_step;
`endif

    assign v0     = port0.req_valid;
    assign v1     = port1.req_valid;
    assign sel_a  = pick ? port1.req_a  : port0.req_a;
    assign sel_b  = pick ? port1.req_b  : port0.req_b;
    assign sel_op = pick ? port1.req_op : port0.req_op;
    assign resp_ready_sel = grant_id ? port1.resp_ready : port0.resp_ready;

    // last_grant resets to 1 so that a tie straight after reset goes to requester 0
    always_comb begin
        pick = 1'b0;
        if (PRIO_FIXED != 0)
            pick = !v0;
        else if (v0 && v1)
            pick = !last_grant;
        else
            pick = v1;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        exec_done  = 1'b0;
        cap_r      = '0;
        cap_zero   = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
`ifdef ALU_SCHED_MULTISHIFT_EN
        shift_step = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rst && (v0 || v1)) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_SCHED_MULTISHIFT_EN
                // lat_a doubles as the shift accumulator; a zero count bypasses the ALU
                if (lat_op == 4'b0101 || lat_op == 4'b0110) begin
                    if (shift_cnt == 6'd0) begin
                        exec_done = 1'b1;
                        cap_r     = lat_a;
                        cap_zero  = (lat_a == 64'd0);
                    end else begin
                        alu_a      = lat_a;
                        alu_op     = lat_op;
                        shift_step = 1'b1;
                        if (shift_cnt == 6'd1) begin
                            exec_done = 1'b1;
                            cap_r     = alu_r;
                            cap_zero  = alu_zero;
                        end
                    end
                end else begin
                    alu_a     = lat_a;
                    alu_b     = lat_b;
                    alu_op    = lat_op;
                    exec_done = 1'b1;
                    cap_r     = alu_r;
                    cap_zero  = alu_zero;
                end
`else
                alu_a     = lat_a;
                alu_b     = lat_b;
                alu_op    = lat_op;
                exec_done = 1'b1;
                cap_r     = alu_r;
                cap_zero  = alu_zero;
`endif
                if (exec_done)
                    next_state = RESP;
            end
            RESP: begin
                if (resp_ready_sel)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            res_r      <= '0;
            res_zero   <= 1'b0;
`ifdef ALU_SCHED_MULTISHIFT_EN
            shift_cnt  <= '0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                grant_id   <= pick;
                last_grant <= pick;
                lat_a      <= sel_a;
                lat_b      <= sel_b;
                lat_op     <= sel_op;
`ifdef ALU_SCHED_MULTISHIFT_EN
                shift_cnt  <= sel_b[5:0];
`endif
            end
`ifdef ALU_SCHED_MULTISHIFT_EN
            if (shift_step) begin
                lat_a     <= alu_r;
                shift_cnt <= shift_cnt - 6'd1;
            end
`endif
            if (exec_done) begin
                res_r    <= cap_r;
                res_zero <= cap_zero;
            end
        end
    end

    // response data is forced to zero whenever its valid is low
    assign in_resp          = (state == RESP);
    assign port0.req_ready  = accept && !pick;
    assign port1.req_ready  = accept && pick;
    assign port0.resp_valid = in_resp && !grant_id;
    assign port1.resp_valid = in_resp && grant_id;
    assign port0.resp_r     = port0.resp_valid ? res_r : 64'd0;
    assign port1.resp_r     = port1.resp_valid ? res_r : 64'd0;
    assign port0.resp_zero  = port0.resp_valid && res_zero;
    assign port1.resp_zero  = port1.resp_valid && res_zero;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: round-robin instance plus a fixed-priority instance,
// each wired to a small reference ALU model.
module tb_alu_sched;

    logic        clk;
    logic        rst;
    logic [63:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic [63:0] falu_a, falu_b, falu_r;
    logic [3:0]  falu_op;
    logic        falu_zero;
    int          checks;
    int          errors;

    alu_sched_if p0 ();
    alu_sched_if p1 ();
    alu_sched_if f0 ();
    alu_sched_if f1 ();

    alu_sched #(.PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst), .port0(p0), .port1(p1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_zero(alu_zero)
    );

    alu_sched #(.PRIO_FIXED(1)) dut_fix (
        .clk(clk), .rst(rst), .port0(f0), .port1(f1),
        .alu_a(falu_a), .alu_b(falu_b), .alu_op(falu_op),
        .alu_r(falu_r), .alu_zero(falu_zero)
    );

    // reference ALU: shifts are always by one position, unknown opcodes give 0
    function automatic logic [63:0] alu_calc(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return a << 1;
            4'b0110: return a >> 1;
            default: return 64'd0;
        endcase
    endfunction

    assign alu_r     = alu_calc(alu_a, alu_b, alu_op);
    assign alu_zero  = (alu_r == 64'd0);
    assign falu_r    = alu_calc(falu_a, falu_b, falu_op);
    assign falu_zero = (falu_r == 64'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // one complete requester-0 transaction with response ready held high
    task automatic apply_stimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] op, input logic [63:0] exp_r,
                                  input logic exp_zero, input int exec_cycles,
                                  input logic [3:0] exp_alu_op);
        p0.req_valid  = 1'b1;
        p0.req_a      = a;
        p0.req_b      = b;
        p0.req_op     = op;
        p0.resp_ready = 1'b1;
        #1;
        check_output({tag, " ready"}, p0.req_ready, 1'b1);
        tick();
        p0.req_valid = 1'b0;
        #1;
        check_output({tag, " alu_op"}, alu_op, exp_alu_op);
        for (int k = 0; k < exec_cycles; k++) begin
            check_output({tag, " early valid"}, p0.resp_valid, 1'b0);
            tick();
        end
        check_output({tag, " valid"}, p0.resp_valid, 1'b1);
        check_output({tag, " r"}, p0.resp_r, exp_r);
        check_output({tag, " zero"}, p0.resp_zero, exp_zero);
        tick();
        check_output({tag, " done"}, p0.resp_valid, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        p0.req_valid = 0; p0.req_a = 0; p0.req_b = 0; p0.req_op = 0; p0.resp_ready = 0;
        p1.req_valid = 0; p1.req_a = 0; p1.req_b = 0; p1.req_op = 0; p1.resp_ready = 0;
        f0.req_valid = 0; f0.req_a = 0; f0.req_b = 0; f0.req_op = 0; f0.resp_ready = 0;
        f1.req_valid = 0; f1.req_a = 0; f1.req_b = 0; f1.req_op = 0; f1.resp_ready = 0;

        // reset holds everything quiet even with a request pending
        p0.req_valid = 1'b1;
        tick();
        tick();
        check_output("rst ready0", p0.req_ready, 1'b0);
        check_output("rst valid0", p0.resp_valid, 1'b0);
        check_output("rst alu_a", alu_a, 64'd0);
        check_output("rst resp_r0", p0.resp_r, 64'd0);
        p0.req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // round-robin alternation with both requesters always valid
        p0.req_valid = 1; p0.req_a = 7; p0.req_b = 7; p0.req_op = 4'b0001; p0.resp_ready = 1;
        p1.req_valid = 1; p1.req_a = 9; p1.req_b = 9; p1.req_op = 4'b0001; p1.resp_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_output("rr ready0", p0.req_ready, (i % 2) == 0);
            check_output("rr ready1", p1.req_ready, (i % 2) == 1);
            tick();
            check_output("rr exec ready", p0.req_ready | p1.req_ready, 1'b0);
            tick();
            check_output("rr resp0", p0.resp_valid, (i % 2) == 0);
            check_output("rr resp1", p1.resp_valid, (i % 2) == 1);
            check_output("rr r", p0.resp_r | p1.resp_r, 64'd0);
            check_output("rr zero", p0.resp_zero | p1.resp_zero, 1'b1);
            tick();
        end
        p0.req_valid = 0;
        p1.req_valid = 0;
        p1.resp_ready = 0;
        #1;

        // single add on requester 0, response in cycle 2
        p0.req_valid = 1; p0.req_a = 5; p0.req_b = 3; p0.req_op = 4'b0000; p0.resp_ready = 1;
        #1;
        check_output("add ready0", p0.req_ready, 1'b1);
        check_output("add ready1", p1.req_ready, 1'b0);
        tick();
        p0.req_valid = 0;
        #1;
        check_output("add alu_a", alu_a, 64'd5);
        check_output("add alu_b", alu_b, 64'd3);
        check_output("add exec valid", p0.resp_valid, 1'b0);
        tick();
        check_output("add valid", p0.resp_valid, 1'b1);
        check_output("add r", p0.resp_r, 64'd8);
        check_output("add zero", p0.resp_zero, 1'b0);
        check_output("add resp1 idle", p1.resp_valid, 1'b0);
        tick();
        check_output("add after valid", p0.resp_valid, 1'b0);
        check_output("idle alu_a", alu_a, 64'd0);
        check_output("idle resp_r", p0.resp_r, 64'd0);

        // requester 1 stalls its response; requester 0 keeps asking
        p0.req_valid = 1; p0.req_a = 1; p0.req_b = 1; p0.req_op = 4'b0000;
        p1.req_valid = 1; p1.req_a = 20; p1.req_b = 22; p1.req_op = 4'b0000; p1.resp_ready = 0;
        #1;
        check_output("stall ready1", p1.req_ready, 1'b1);
        check_output("stall ready0", p0.req_ready, 1'b0);
        tick();
        p1.req_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_output("stall valid1", p1.resp_valid, 1'b1);
            check_output("stall r1", p1.resp_r, 64'd42);
            check_output("stall ready", p0.req_ready | p1.req_ready, 1'b0);
            check_output("stall valid0", p0.resp_valid, 1'b0);
            tick();
        end
        p1.resp_ready = 1;
        #1;
        check_output("handshake no accept", p0.req_ready, 1'b0);
        tick();
        check_output("stall done", p1.resp_valid, 1'b0);
        check_output("post ready0", p0.req_ready, 1'b1);
        p0.req_valid = 0;
        #1;

        // reset while EXEC discards the operation
        p1.req_valid = 1; p1.req_a = 3; p1.req_b = 4; p1.req_op = 4'b0000;
        #1;
        check_output("rx ready1", p1.req_ready, 1'b1);
        tick();
        p1.req_valid = 0;
        #1;
        check_output("rx exec alu_a", alu_a, 64'd3);
        rst = 1'b1;
        #1;
        check_output("rx alu_a", alu_a, 64'd0);
        check_output("rx alu_op", {60'd0, alu_op}, 64'd0);
        check_output("rx valid1", p1.resp_valid, 1'b0);
        check_output("rx r1", p1.resp_r, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("rx no resp", p0.resp_valid | p1.resp_valid, 1'b0);
        end
        p0.req_valid = 1;
        p1.req_valid = 1;
        #1;
        check_output("rx prefer0", p0.req_ready, 1'b1);
        check_output("rx not1", p1.req_ready, 1'b0);
        p0.req_valid = 0;
        p1.req_valid = 0;
        #1;

        // opcode table on requester 0
        apply_stimulus("and", 64'hF0F0, 64'h0FF0, 4'b0010, 64'h00F0, 1'b0, 1, 4'b0010);
        apply_stimulus("xor", 64'd5, 64'd5, 4'b0100, 64'd0, 1'b1, 1, 4'b0100);
        apply_stimulus("fwd", 64'h10, 64'h20, 4'b1010, 64'd0, 1'b1, 1, 4'b1010);
        apply_stimulus("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 64'd0, 1'b1, 1, 4'b0000);
        apply_stimulus("sub", 64'd3, 64'd5, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1, 4'b0001);
        apply_stimulus("or", 64'hA, 64'h5, 4'b0011, 64'hF, 1'b0, 1, 4'b0011);
`ifdef ALU_SCHED_MULTISHIFT_EN
        apply_stimulus("shl10", 64'd1, 64'd10, 4'b0101, 64'h400, 1'b0, 10, 4'b0101);
        apply_stimulus("shl0", 64'h1234, 64'd0, 4'b0101, 64'h1234, 1'b0, 1, 4'b0000);
        apply_stimulus("shr4", 64'h100, 64'd4, 4'b0110, 64'h10, 1'b0, 4, 4'b0110);
`else
        apply_stimulus("shl", 64'd1, 64'd10, 4'b0101, 64'd2, 1'b0, 1, 4'b0101);
        apply_stimulus("shr", 64'h100, 64'd4, 4'b0110, 64'h80, 1'b0, 1, 4'b0110);
`endif

        // fixed priority: requester 1 never wins while requester 0 is valid
        f0.req_valid = 1; f0.req_a = 2; f0.req_b = 3; f0.req_op = 4'b0000; f0.resp_ready = 1;
        f1.req_valid = 1; f1.req_a = 4; f1.req_b = 4; f1.req_op = 4'b0000; f1.resp_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_output("fix ready0", f0.req_ready, 1'b1);
            check_output("fix ready1", f1.req_ready, 1'b0);
            tick();
            tick();
            check_output("fix resp0", f0.resp_valid, 1'b1);
            check_output("fix resp1", f1.resp_valid, 1'b0);
            check_output("fix r0", f0.resp_r, 64'd5);
            tick();
        end
        f0.req_valid = 0;
        f1.req_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0, meaning 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have, per requester n in {0,1}: reqn_valid in 1, reqn_ready out 1, reqn_a in 64, reqn_b in 64, reqn_op in 4 (ALU opcode encoding).
REQ-005 SHALL have, per requester n: respn_valid out 1, respn_ready in 1, respn_r out 64, respn_zero out 1.
REQ-006 SHALL drive the shared ALU via alu_a out 64, alu_b out 64, alu_op out 4, and receive alu_r in 64, alu_zero in 1 (combinational ALU, same cycle).

Function
REQ-007 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-008 IDLE: when any reqn_valid=1, SHALL grant one requester, assert only its reqn_ready combinationally that cycle, latch a/b/op and grant id, go to EXEC.
REQ-009 reqn_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-010 Arbitration, PRIO_FIXED=0: single requester wins; both valid -> requester other than last granted wins; after reset requester 0 preferred.
REQ-011 Arbitration, PRIO_FIXED=1: requester 0 wins whenever req0_valid=1.
REQ-012 EXEC, non-shift op (op not 0101/0110): SHALL drive alu_a/alu_b/alu_op from latched values, capture alu_r/alu_zero at end of cycle, go to RESP (one EXEC cycle).
REQ-013 Opcodes 0111-1111 SHALL be forwarded unchanged; result 0, zero 1, no error signalling.
REQ-014 RESP: SHALL assert respn_valid for the granted requester only, holding respn_r/respn_zero stable until respn_ready=1; on that edge return to IDLE.
REQ-015 Non-shift latency: accept edge at cycle 0 -> respn_valid high in cycle 2.
REQ-016 New request SHALL not be accepted in the cycle the response handshake completes (earliest accept the following IDLE cycle).
REQ-017 alu_a/alu_b/alu_op SHALL be 0 outside EXEC.
REQ-018 respn_r/respn_zero SHALL be 0 when respn_valid=0.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, all ready/valid outputs 0, all data outputs 0, round-robin pointer to prefer requester 0.
REQ-020 Reset during EXEC or RESP SHALL discard the operation; no response is ever issued for it.

Configuration
REQ-021 Macro ALU_SCHED_MULTISHIFT_EN SHALL select multi-cycle shifts.
REQ-022 With ALU_SCHED_MULTISHIFT_EN: for op 0101/0110, shift count = latched b[5:0]; EXEC SHALL issue count successive shift-by-1 ALU ops, feeding alu_r back into alu_a each cycle, alu_b=0; result/zero from final cycle; EXEC lasts max(count,1) cycles.
REQ-023 With ALU_SCHED_MULTISHIFT_EN and count 0: EXEC one cycle, ALU not used (alu_op=0, alu_a/alu_b=0), result = latched a, zero = (a==0).
REQ-024 Without ALU_SCHED_MULTISHIFT_EN: shifts SHALL behave as REQ-012 (single shift-by-1, b ignored).

Verification
REQ-025 req0 a=5, b=3, op=0000, resp0_ready=1 -> resp0_valid in cycle 2, resp0_r=8, zero=0, req1 side idle.
REQ-026 Both valid every cycle, PRIO_FIXED=0, op=0001 with a=b -> grants alternate 0,1,0,1; each response r=0, zero=1.
REQ-027 PRIO_FIXED=1, both valid continuously -> requester 1 never granted over 4 operations.
REQ-028 MULTISHIFT_EN: a=1, b=10, op=0101 -> 10 EXEC cycles, r=0x400; b=0 -> r=a, 1 EXEC cycle; macro off -> r=2.
REQ-029 resp1_ready held 0 for 5 cycles -> resp1_valid/r stable, req0/req1_ready 0 throughout; rst pulse in EXEC -> no response, all outputs 0, next accept prefers requester 0.
